k423_pipe_stage: RTL
====================

# k423_pipe_stage

Generic, parametrised pipeline stage register with valid/ready handshake, flush, stall and an optional skid buffer. It supersedes the hand-written per-stage registers (if/id, id/ex, ...) so that every stage boundary in the k423 core shares one verified block. It provides full-throughput back-pressure, order-preserving buffering and priority flush. It sits between any two core stages; the payload (pc, inst, decoded fields) is packed by the instantiating stage.

## Interface
Parameters:
- DATA_W, 64, payload width in bits (32-bit pc + 32-bit inst by default); legal range 1..1024
- CLR_ON_FLUSH, 1, 1: payload registers load RST_VAL on flush; 0: payload held, only valids cleared
- RST_VAL, '0, DATA_W-bit payload value on reset (and on flush when CLR_ON_FLUSH=1)

Ports:
- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  reset; asynchronous, active-high
- flush_i  in  1  kill all held entries (branch redirect/exception)
- stall_i  in  1  hold output entry (e.g. load-use); masks out_rdy_i
- in_vld_i  in  1  upstream entry valid
- in_rdy_o  out  1  stage can accept an entry this cycle
- in_data_i  in  DATA_W  upstream payload
- out_vld_o  out  1  output entry valid
- out_rdy_i  in  1  downstream accepts
- out_data_o  out  DATA_W  output payload
- cnt_o  out  2  entries held: 0..1 without skid, 0..2 with skid

## Operation
- Effective downstream ready: ordy = out_rdy_i & ~stall_i.
- Input handshake: in_fire = in_vld_i & in_rdy_o. Output handshake: out_fire = out_vld_o & ordy.
- Main register M (M_vld, M_data) drives out_vld_o/out_data_o directly (registered outputs).
- Skid register S (S_vld, S_data) is present only with skid enabled (see Configuration).
- Update rules, evaluated in priority order:
  - flush_i=1: M_vld<=0, S_vld<=0; any in_fire that cycle is discarded; payloads per CLR_ON_FLUSH.
  - S_vld=1 and out_fire: M<=S, S_vld<=0. in_rdy_o is 0, so no input is taken.
  - S_vld=0, in_fire, and (M_vld=0 or out_fire): M<=input, M_vld<=1.
  - S_vld=0, in_fire, M_vld=1, no out_fire: S<=input, S_vld<=1.
  - S_vld=0, no in_fire, out_fire: M_vld<=0; M_data held.
  - Otherwise hold.
- Entries leave in acceptance order; no entry is duplicated or dropped except by flush.
- out_data_o is stable while out_vld_o=1 and out_fire=0.
- stall_i does not block loading an empty M. It only prevents M from draining.
- cnt_o = M_vld + S_vld.

## Timing
- Reset (async assert, synchronous deassert by system): out_vld_o=0, out_data_o=RST_VAL, cnt_o=0, S_vld=0, in_rdy_o=1.
- Latency: an entry accepted in cycle N is visible on out_vld_o/out_data_o in cycle N+1.
- Throughput: 1 entry/cycle sustained when ordy=1.
- With skid: in_rdy_o = ~S_vld (registered, no combinational path from out_rdy_i/stall_i). After ordy drops, one extra entry is absorbed into S. in_rdy_o falls the following cycle.
- Without skid: in_rdy_o = ~M_vld | ordy (combinational from out_rdy_i and stall_i).
- Flush while full (cnt_o=2): next cycle cnt_o=0 and in_rdy_o=1.
- Flush coincident with out_fire: the downstream consumes the current output this cycle; the flush applies to state only.
- Reset asserted mid-transfer: all state is cleared immediately, regardless of clock.

## Configuration
- K423_PIPE_SKID_EN defined: S register is instantiated; in_rdy_o is registered as above; cnt_o ranges 0..2.
- Not defined: S is absent (S_vld tied to 0); in_rdy_o = ~M_vld | ordy; cnt_o ranges 0..1, bit 1 tied to 0.
- Handshake ordering and flush semantics are identical in both builds.

## Test plan
- Stream: DATA_W=64, in_vld_i=1 with data 0x1,0x2,... for 8 cycles, out_rdy_i=1 -> out_data_o shows 0x1..0x8 on consecutive cycles, each one cycle after acceptance; cnt_o=1 throughout.
- Skid (SKID_EN): stream 0xA,0xB,0xC; drop out_rdy_i while 0xA is on the output -> 0xB is absorbed into S, cnt_o=2, in_rdy_o=0 the next cycle. Re-raise out_rdy_i -> outputs 0xA,0xB,0xC in order, no gaps.
- Stall: load-use stall_i=1 for 3 cycles with out_rdy_i=1 and out_data_o=0x55 -> out_data_o holds 0x55, no out_fire. Release -> 0x55 is consumed exactly once.
- Flush when full: cnt_o=2 and in_vld_i=1 with flush_i=1 -> next cycle out_vld_o=0, cnt_o=0, in_rdy_o=1. With CLR_ON_FLUSH=1, out_data_o=RST_VAL. The input offered that cycle never appears.
- Async reset mid-stream: assert rst_i between clock edges while cnt_o=2 -> out_vld_o=0 and cnt_o=0 immediately. First entry after release arrives one cycle after acceptance.
- Randomised ready/valid/stall over 10k cycles against a reference queue model -> zero ordering mismatches. Non-skid build also matches.

Source files
------------

// File: rtl/k423_pipe_stage.sv
// ---------------------------------------------------------------------------
// k423_pipe_stage
//
// Generic pipeline stage register with valid/ready handshake, priority flush,
// stall and an optional skid buffer. It is shared by every stage boundary of
// the k423 core (if/id, id/ex, ...). The instantiating stage packs its own
// payload into in_data_i.
//
// Build option:
//   K423_PIPE_SKID_EN  defined   -> skid register S present, in_rdy_o is
//                                   registered (~S_vld), cnt_o in 0..2
//                      undefined -> no skid, in_rdy_o = ~M_vld | ordy
//                                   (combinational), cnt_o in 0..1
//
// Parameters:
//   DATA_W        payload width in bits (1..1024)
//   CLR_ON_FLUSH  1: payload registers load RST_VAL on flush
//                 0: payloads held on flush, only valids cleared
//   RST_VAL       payload value after reset (and after flush if CLR_ON_FLUSH)
//
// Ports:
//   clk_i       clock, all state on rising edge
//   rst_i       asynchronous active-high reset
//   flush_i     kill all held entries; an input offered that cycle is dropped
//   stall_i     hold the output entry; masks out_rdy_i
//   in_vld_i    upstream entry valid
//   in_rdy_o    stage accepts an entry this cycle
//   in_data_i   upstream payload
//   out_vld_o   output entry valid (registered)
//   out_rdy_i   downstream accepts
//   out_data_o  output payload (registered)
//   cnt_o       number of entries held
// ---------------------------------------------------------------------------
module k423_pipe_stage #(
  parameter int unsigned       DATA_W       = 64,
  parameter int unsigned       CLR_ON_FLUSH = 1,
  parameter logic [DATA_W-1:0] RST_VAL      = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              in_vld_i,
  output logic              in_rdy_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_vld_o,
  input  logic              out_rdy_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        cnt_o
);

  // Main register: drives the outputs directly.
  logic              m_vld_q;
  logic              m_vld_d;
  logic [DATA_W-1:0] m_data_q;
  logic [DATA_W-1:0] m_data_d;

`ifdef K423_PIPE_SKID_EN
  // Skid register: catches the one entry accepted in the cycle the
  // downstream stopped, since in_rdy_o only reacts one cycle later.
  logic              s_vld_q;
  logic              s_vld_d;
  logic [DATA_W-1:0] s_data_q;
  logic [DATA_W-1:0] s_data_d;
`endif

  logic ordy;
  logic in_fire;
  logic out_fire;

  // Stall masks the downstream ready; it never blocks filling an empty M.
  assign ordy     = out_rdy_i & ~stall_i;
  assign out_fire = m_vld_q & ordy;
  assign in_fire  = in_vld_i & in_rdy_o;

`ifdef K423_PIPE_SKID_EN
  assign in_rdy_o = ~s_vld_q;
  assign cnt_o    = {1'b0, m_vld_q} + {1'b0, s_vld_q};
`else
  assign in_rdy_o = ~m_vld_q | ordy;
  assign cnt_o    = {1'b0, m_vld_q};
`endif

  assign out_vld_o  = m_vld_q;
  assign out_data_o = m_data_q;

  // Next-state selection in priority order: flush, S->M refill, load M,
  // load S, drain M, hold. With skid, in_fire already implies S is empty.
  always_comb begin
    m_vld_d  = m_vld_q;
    m_data_d = m_data_q;
`ifdef K423_PIPE_SKID_EN
    s_vld_d  = s_vld_q;
    s_data_d = s_data_q;
`endif
    if (flush_i) begin
      m_vld_d = 1'b0;
`ifdef K423_PIPE_SKID_EN
      s_vld_d = 1'b0;
`endif
      if (CLR_ON_FLUSH != 0) begin
        m_data_d = RST_VAL;
`ifdef K423_PIPE_SKID_EN
        s_data_d = RST_VAL;
`endif
      end
    end
`ifdef K423_PIPE_SKID_EN
    else if (s_vld_q && out_fire) begin
      // M stays valid: it takes the older entry waiting in S.
      m_data_d = s_data_q;
      s_vld_d  = 1'b0;
    end
`endif
    else if (in_fire && (!m_vld_q || out_fire)) begin
      m_vld_d  = 1'b1;
      m_data_d = in_data_i;
    end
`ifdef K423_PIPE_SKID_EN
    else if (in_fire) begin
      s_vld_d  = 1'b1;
      s_data_d = in_data_i;
    end
`endif
    else if (out_fire) begin
      m_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_vld_q  <= 1'b0;
      m_data_q <= RST_VAL;
    end else begin
      m_vld_q  <= m_vld_d;
      m_data_q <= m_data_d;
    end
  end

`ifdef K423_PIPE_SKID_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s_vld_q  <= 1'b0;
      s_data_q <= RST_VAL;
    end else begin
      s_vld_q  <= s_vld_d;
      s_data_q <= s_data_d;
    end
  end
`endif

endmodule
